// File: rtl/asteroid_collision_detector.sv
// Per-frame collision scanner: walks every asteroid slot once per frame_tick and
// tests it against a snapshot of the bullet point and the ship bounding box.
module asteroid_collision_detector #(
  parameter int ASTEROID_COUNT = 8,
  parameter int ENTITY_SIZE    = 34,
  parameter int ASTEROID_SIZE  = 16,
  parameter int SHIP_SIZE      = 16
) (
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic                                      frame_tick,
  input  logic [ASTEROID_COUNT-1:0][ENTITY_SIZE-1:0] asteroids_data,
  input  logic                                      bullet_valid,
  input  logic [9:0]                                bullet_x,
  input  logic [9:0]                                bullet_y,
  input  logic [9:0]                                ship_x,
  input  logic [9:0]                                ship_y,
  output logic                                      delete_asteroid,
  output logic [9:0]                                asteroid_address,
  output logic                                      bullet_hit,
  output logic                                      ship_hit,
  output logic [15:0]                               score,
  output logic                                      busy,
  output logic                                      scan_done,
  output logic [1:0]                                fsm_state
);

  // Pulse semantics: frame_tick is sampled only in IDLE (no queueing while busy);
  // delete_asteroid, bullet_hit, ship_hit and scan_done are single-cycle strobes,
  // and asteroid_address is meaningful only while delete_asteroid is high.

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HIT  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [9:0]  LAST_INDEX = 10'(ASTEROID_COUNT - 1);
  localparam logic [10:0] AST_EXT    = 11'(ASTEROID_SIZE);
  localparam logic [10:0] SHIP_EXT   = 11'(SHIP_SIZE);

  state_t     state;
  state_t     next_state;
  logic [9:0] index;

  logic       snap_bullet_valid;
  logic [9:0] snap_bullet_x;
  logic [9:0] snap_bullet_y;
  logic [9:0] snap_ship_x;
  logic [9:0] snap_ship_y;
  logic       ship_hit_seen;

  logic [ENTITY_SIZE-1:0] cur;
  logic                   ast_active;
  logic [9:0]             ast_x;
  logic [9:0]             ast_y;
  logic                   slot_bullet;
  logic                   slot_ship;
  logic                   slot_hit;
  logic                   last_slot;
  logic                   unused_entity_bits;

  // Point-in-span test widened to 11 bits so a box near 1023 never wraps to 0.
  function automatic logic in_span(input logic [9:0] a, input logic [9:0] p,
                                   input logic [10:0] ext);
    logic [10:0] ae;
    logic [10:0] pe;
    ae = {1'b0, a};
    pe = {1'b0, p};
    return (ae <= pe) && (pe < ae + ext);
  endfunction

  function automatic logic spans_overlap(input logic [9:0] s, input logic [9:0] a);
    logic [10:0] se;
    logic [10:0] ae;
    se = {1'b0, s};
    ae = {1'b0, a};
    return (se < ae + AST_EXT) && (ae < se + SHIP_EXT);
  endfunction

  always_comb begin
    cur = '0;
    for (int i = 0; i < ASTEROID_COUNT; i++) begin
      if (index == 10'(i)) cur = asteroids_data[i];
    end
  end

  assign ast_active         = cur[33];
  assign ast_y              = cur[25:16];
  assign ast_x              = cur[15:6];
  assign unused_entity_bits = ^cur;

  assign slot_bullet = ast_active && snap_bullet_valid
                    && in_span(ast_x, snap_bullet_x, AST_EXT)
                    && in_span(ast_y, snap_bullet_y, AST_EXT);
  assign slot_ship   = ast_active
                    && spans_overlap(snap_ship_x, ast_x)
                    && spans_overlap(snap_ship_y, ast_y);
  assign slot_hit    = slot_bullet || slot_ship;
  assign last_slot   = (index == LAST_INDEX);
  assign fsm_state   = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: if (frame_tick) next_state = SCAN;
      SCAN: begin
        if (slot_hit)       next_state = HIT;
        else if (last_slot) next_state = DONE;
        else                next_state = SCAN;
      end
      HIT:  next_state = last_slot ? DONE : SCAN;
      DONE: next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Datapath and registered outputs; strobes are loaded on the edge entering
  // the state that owns them, so they are high exactly during HIT or DONE.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      index             <= '0;
      snap_bullet_valid <= 1'b0;
      snap_bullet_x     <= '0;
      snap_bullet_y     <= '0;
      snap_ship_x       <= '0;
      snap_ship_y       <= '0;
      ship_hit_seen     <= 1'b0;
      score             <= '0;
      delete_asteroid   <= 1'b0;
      asteroid_address  <= '0;
      bullet_hit        <= 1'b0;
      ship_hit          <= 1'b0;
      busy              <= 1'b0;
      scan_done         <= 1'b0;
    end else begin
      delete_asteroid <= 1'b0;
      bullet_hit      <= 1'b0;
      ship_hit        <= 1'b0;
      scan_done       <= (next_state == DONE);
      busy            <= (next_state != IDLE);
      case (state)
        IDLE: begin
          if (frame_tick) begin
            index             <= '0;
            snap_bullet_valid <= bullet_valid;
            snap_bullet_x     <= bullet_x;
            snap_bullet_y     <= bullet_y;
            snap_ship_x       <= ship_x;
            snap_ship_y       <= ship_y;
            ship_hit_seen     <= 1'b0;
          end
        end
        SCAN: begin
          if (slot_hit) begin
            delete_asteroid  <= 1'b1;
            asteroid_address <= index;
            if (slot_bullet) begin
              bullet_hit        <= 1'b1;
              snap_bullet_valid <= 1'b0;
              if (score != 16'hFFFF) score <= score + 16'd1;
            end
            if (slot_ship && !ship_hit_seen) begin
              ship_hit      <= 1'b1;
              ship_hit_seen <= 1'b1;
            end
          end else if (!last_slot) begin
            index <= index + 10'd1;
          end
        end
        HIT: begin
          if (!last_slot) index <= index + 10'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_asteroid_collision_detector.sv
// Directed bench for asteroid_collision_detector with 8 slots and default sizes.
module tb_asteroid_collision_detector;

  logic             clk;
  logic             reset_n;
  logic             frame_tick;
  logic [7:0][33:0] ast_data;
  logic             bullet_valid;
  logic [9:0]       bullet_x;
  logic [9:0]       bullet_y;
  logic [9:0]       ship_x;
  logic [9:0]       ship_y;
  logic             delete_asteroid;
  logic [9:0]       asteroid_address;
  logic             bullet_hit;
  logic             ship_hit;
  logic [15:0]      score;
  logic             busy;
  logic             scan_done;
  logic [1:0]       fsm_state;

  int checks = 0;
  int errors = 0;

  logic [9:0] del_q[$];
  logic [9:0] sh_addr_q[$];
  logic [9:0] exp_q[$];
  int         bh_cnt;
  int         sh_cnt;
  int         sd_cnt;
  int         lat;

  asteroid_collision_detector #(
    .ASTEROID_COUNT(8), .ENTITY_SIZE(34), .ASTEROID_SIZE(16), .SHIP_SIZE(16)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .asteroids_data(ast_data), .bullet_valid(bullet_valid),
    .bullet_x(bullet_x), .bullet_y(bullet_y), .ship_x(ship_x), .ship_y(ship_y),
    .delete_asteroid(delete_asteroid), .asteroid_address(asteroid_address),
    .bullet_hit(bullet_hit), .ship_hit(ship_hit), .score(score), .busy(busy),
    .scan_done(scan_done), .fsm_state(fsm_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // output monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (delete_asteroid) del_q.push_back(asteroid_address);
    if (bullet_hit) bh_cnt++;
    if (ship_hit) begin
      sh_cnt++;
      sh_addr_q.push_back(asteroid_address);
    end
    if (scan_done) sd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_deletes(input string tag);
    chk({tag, "_del_count"}, 32'(del_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < del_q.size(); i++)
      chk({tag, "_del_addr"}, 32'(del_q[i]), 32'(exp_q[i]));
  endtask

  task automatic clear_mon();
    del_q.delete();
    sh_addr_q.delete();
    exp_q.delete();
    bh_cnt = 0;
    sh_cnt = 0;
    sd_cnt = 0;
  endtask

  task automatic set_slot(input int i, input logic [9:0] x, input logic [9:0] y);
    ast_data[i] = {1'b1, 7'd0, y, x, 6'd0};
  endtask

  task automatic set_bullet(input logic v, input logic [9:0] x, input logic [9:0] y);
    bullet_valid = v;
    bullet_x     = x;
    bullet_y     = y;
  endtask

  // driver: pulse frame_tick and measure cycles until scan_done (-1 on timeout)
  task automatic run_scan(input int retick_at, output int cycles);
    bit done;
    @(negedge clk);
    clear_mon();
    frame_tick = 1'b1;
    cycles = -1;
    done = 1'b0;
    for (int c = 1; c <= 60 && !done; c++) begin
      @(negedge clk);
      frame_tick = (c == retick_at);
      if (scan_done) begin
        cycles = c;
        done = 1'b1;
      end
    end
    frame_tick = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset_n  = 1'b0;
    frame_tick = 1'b0;
    ast_data = '0;
    set_bullet(1'b0, 10'd0, 10'd0);
    ship_x = 10'd600;
    ship_y = 10'd400;
    clear_mon();
    repeat (3) @(negedge clk);

    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_score", 32'(score), 32'd0);
    chk("rst_delete", 32'(delete_asteroid), 32'd0);
    chk("rst_addr", 32'(asteroid_address), 32'd0);
    chk("rst_state", 32'(fsm_state), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // empty field
    run_scan(0, lat);
    chk("empty_lat", 32'(lat), 32'd9);
    check_deletes("empty");
    chk("empty_score", 32'(score), 32'd0);

    // single bullet hit in slot 3
    set_slot(3, 10'd100, 10'd50);
    set_bullet(1'b1, 10'd108, 10'd60);
    run_scan(0, lat);
    exp_q.push_back(10'd3);
    chk("one_lat", 32'(lat), 32'd10);
    check_deletes("one");
    chk("one_bh", 32'(bh_cnt), 32'd1);
    chk("one_sh", 32'(sh_cnt), 32'd0);
    chk("one_score", 32'(score), 32'd1);

    // two slots contain the bullet: only the first is consumed
    ast_data = '0;
    set_slot(2, 10'd300, 10'd300);
    set_slot(5, 10'd302, 10'd298);
    set_bullet(1'b1, 10'd305, 10'd305);
    run_scan(0, lat);
    exp_q.push_back(10'd2);
    chk("dbl_lat", 32'(lat), 32'd10);
    check_deletes("dbl");
    chk("dbl_bh", 32'(bh_cnt), 32'd1);
    chk("dbl_score", 32'(score), 32'd2);

    // ship overlaps two asteroids: two deletes, one ship_hit with the first
    ast_data = '0;
    set_slot(1, 10'd210, 10'd205);
    set_slot(6, 10'd190, 10'd195);
    set_bullet(1'b0, 10'd0, 10'd0);
    ship_x = 10'd200;
    ship_y = 10'd200;
    run_scan(0, lat);
    exp_q.push_back(10'd1);
    exp_q.push_back(10'd6);
    chk("ship_lat", 32'(lat), 32'd11);
    check_deletes("ship");
    chk("ship_sh", 32'(sh_cnt), 32'd1);
    chk("ship_sh_addr", 32'(sh_addr_q.size() > 0 ? sh_addr_q[0] : 10'h3FF), 32'd1);
    chk("ship_bh", 32'(bh_cnt), 32'd0);
    chk("ship_score", 32'(score), 32'd2);

    // right edge: no wrap at 1023, and exclusive upper bound of the box
    ast_data = '0;
    ship_x = 10'd600;
    ship_y = 10'd400;
    set_slot(0, 10'd1015, 10'd100);
    set_slot(4, 10'd400, 10'd400);
    set_bullet(1'b1, 10'd5, 10'd105);
    run_scan(0, lat);
    chk("wrap_lat", 32'(lat), 32'd9);
    check_deletes("wrap");
    set_bullet(1'b1, 10'd416, 10'd400);
    run_scan(0, lat);
    check_deletes("edge_out");
    set_bullet(1'b1, 10'd400, 10'd415);
    run_scan(0, lat);
    exp_q.push_back(10'd4);
    check_deletes("edge_in");
    chk("edge_score", 32'(score), 32'd3);

    // mid-scan input changes are ignored
    ast_data = '0;
    set_slot(7, 10'd50, 10'd50);
    set_bullet(1'b1, 10'd55, 10'd55);
    fork
      run_scan(0, lat);
      begin
        @(posedge frame_tick);
        @(negedge clk);
        @(negedge clk);
        set_bullet(1'b0, 10'd900, 10'd900);
      end
    join
    exp_q.push_back(10'd7);
    chk("snap_lat", 32'(lat), 32'd10);
    check_deletes("snap");
    chk("snap_score", 32'(score), 32'd4);

    // score saturation
    force dut.score = 16'hFFFE;
    #1;
    release dut.score;
    set_bullet(1'b1, 10'd55, 10'd55);
    run_scan(0, lat);
    chk("sat_first", 32'(score), 32'h0000FFFF);
    run_scan(0, lat);
    chk("sat_hold", 32'(score), 32'h0000FFFF);
    chk("sat_bh", 32'(bh_cnt), 32'd1);

    // frame_tick while busy is dropped
    ast_data = '0;
    run_scan(3, lat);
    chk("busy_lat", 32'(lat), 32'd9);
    repeat (15) @(negedge clk);
    chk("busy_scans", 32'(sd_cnt), 32'd1);
    chk("busy_idle", 32'(busy), 32'd0);

    // reset during HIT
    set_slot(3, 10'd100, 10'd50);
    set_bullet(1'b1, 10'd108, 10'd60);
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 30 && !seen; c++) begin
        if (delete_asteroid) seen = 1'b1;
        else @(negedge clk);
      end
      chk("rhit_seen", 32'(seen), 32'd1);
    end
    reset_n = 1'b0;
    #1;
    chk("rhit_delete", 32'(delete_asteroid), 32'd0);
    chk("rhit_busy", 32'(busy), 32'd0);
    chk("rhit_score", 32'(score), 32'd0);
    chk("rhit_state", 32'(fsm_state), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    clear_mon();
    repeat (20) @(negedge clk);
    check_deletes("post_rst");
    chk("post_rst_done", 32'(sd_cnt), 32'd0);
    run_scan(0, lat);
    exp_q.push_back(10'd3);
    chk("post_rst_lat", 32'(lat), 32'd10);
    check_deletes("post_rst_scan");
    chk("post_rst_score", 32'(score), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
